code_entry_frontend: RTL and testbench
======================================

Name: code_entry_frontend

Overview:
Front end of the combination-lock datapath, directly upstream of the lock FSM. It turns the raw enter push-button and digit switches into clean single-cycle events:
- Synchronises and debounces the button.
- Compares the switch value against the stored code digit for the current position.
- Drives the lock FSM's enter and correct_digit inputs, tracking the code position in lockstep with the FSM.

Parameters:
DIGIT_W, 4, width of one code digit / switch bus
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a button level change is accepted (>=2)
DB_CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1
CODE0, 4'd3, first code digit
CODE1, 4'd7, second code digit
CODE2, 4'd1, third code digit
MAX_FAILS, 3, consecutive wrong digits that trigger lockout (LOCKOUT_EN only)
LOCKOUT_CYCLES, 1000000, lockout duration in clk cycles (LOCKOUT_EN only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_enter_raw  in  1  raw enter push-button, active-high, asynchronous, bouncing
digit_sw  in  DIGIT_W  raw digit switches, asynchronous
enter  out  1  one-cycle pulse per accepted button press
correct_digit  out  1  valid only while enter=1; 1 = sampled digit matches the code digit at digit_index
digit_index  out  2  current code position: 0, 1, 2, or 3 (=unlocked)
btn_level  out  1  debounced button level (debug)
lockout  out  1  1 while entry is blocked; constant 0 without LOCKOUT_EN

Behaviour:
- Reset: every flop cleared, so enter=0, correct_digit=0, digit_index=0, btn_level=0, lockout=0; debounce counter=0; synchronisers=0.
- Synchronisation: btn_enter_raw and digit_sw each pass through a 2-flop synchroniser; all other logic uses only the synchronised copies.
- Debounce counter:
  - Clears in any cycle where sync_btn == btn_level.
  - Otherwise increments.
  - In the cycle it equals DEBOUNCE_CYCLES-1 while sync_btn != btn_level still holds, btn_level toggles and the counter clears.
  - Any glitch back to btn_level before that point restarts the count.
- Edge detect: a 0->1 transition of btn_level produces enter=1 for exactly one cycle, in the cycle after btn_level rises. Release produces no pulse. Holding the button produces only one pulse.
- Digit sample: in the same cycle btn_level rises, sync_digit is compared with the code digit for digit_index:
  - index 0 -> CODE0, index 1 -> CODE1, index 2 -> CODE2.
  - index 3 -> correct_digit forced 0.
  - The result is registered into correct_digit, aligned with enter.
- Latency: a clean press held stable gives enter at cycle 2 (sync) + DEBOUNCE_CYCLES + 1 after the raw edge.
- correct_digit returns to 0 when enter is 0.
- Position tracker (mirrors the lock FSM), updated on the enter cycle:
  - idx 0: correct -> 1; wrong -> 0.
  - idx 1, 2: correct -> idx+1; wrong -> 0.
  - idx 3: any enter -> 0.
  - digit_index changes the cycle after the enter pulse.
- Boundary: a second press cannot occur sooner than 2*DEBOUNCE_CYCLES after the first, so one enter is in flight at most.
- Reset mid-debounce or mid-pulse: the counter is discarded and no pulse is emitted after release of reset until a fresh debounced rising edge occurs. A button already held through reset release produces one pulse once debounced, because btn_level resets to 0.

Optional Feature:
LOCKOUT_EN
- Defined:
  - A fail counter increments on each enter with correct_digit=0 at idx 0-2.
  - It clears on any correct entry and on reaching idx 3.
  - When the counter reaches MAX_FAILS, lockout=1 for LOCKOUT_CYCLES cycles and the fail counter clears.
  - While lockout=1, enter and correct_digit are forced 0, digit_index holds 0, and debounce/edge logic keeps running, so presses are swallowed.
  - lockout falls after exactly LOCKOUT_CYCLES cycles.
  - reset clears lockout immediately.
- Undefined: lockout tied 0; no fail counter logic.

Test Plan:
- DEBOUNCE_CYCLES=4. Clean press with digit_sw=3 at idx 0 -> single enter pulse 2+4+1 cycles after raw edge with correct_digit=1; digit_index 0->1 the next cycle.
- Bouncy press: raw toggles 1,0,1 at 1-cycle spacing, then holds high 10 cycles -> exactly one enter pulse; holding the button longer produces no further pulses.
- Full sequence 3,7,1 -> three pulses, each with correct_digit=1; digit_index 0->1->2->3. A fourth press with digit 9 -> enter with correct_digit=0, index returns to 0.
- Sequence 3 then 5 -> second pulse has correct_digit=0, index 1->0. Then 3 -> correct_digit=1, index 1.
- Assert reset during debounce count 2 of a press -> all outputs 0, no pulse. Button still held after reset release -> one pulse after the debounce period.
- LOCKOUT_EN, MAX_FAILS=3, LOCKOUT_CYCLES=20:
  - Three wrong digits -> lockout=1 for 20 cycles.
  - A press during lockout -> no enter.
  - After lockout, 3,7,1 -> index reaches 3.

Source files
------------

// File: rtl/code_entry_frontend.sv
// Combination-lock front end: synchronises, debounces and edge-detects the enter button,
// checks the switch digit against the stored code and tracks the code position.
// Optional build macro LOCKOUT_EN adds wrong-digit lockout.
module code_entry_frontend #(
  parameter int unsigned         DIGIT_W         = 4,
  parameter int unsigned         DEBOUNCE_CYCLES = 50000,
  parameter int unsigned         DB_CNT_W        = 16,
  parameter logic [DIGIT_W-1:0]  CODE0           = DIGIT_W'(3),
  parameter logic [DIGIT_W-1:0]  CODE1           = DIGIT_W'(7),
  parameter logic [DIGIT_W-1:0]  CODE2           = DIGIT_W'(1),
  parameter int unsigned         MAX_FAILS       = 3,
  parameter int unsigned         LOCKOUT_CYCLES  = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_enter_raw,
  input  logic [DIGIT_W-1:0] digit_sw,
  output logic               enter,
  output logic               correct_digit,
  output logic [1:0]         digit_index,
  output logic               btn_level,
  output logic               lockout
);

  logic               btn_s1;
  logic               sync_btn;
  logic [DIGIT_W-1:0] dig_s1;
  logic [DIGIT_W-1:0] sync_digit;
  logic [DB_CNT_W-1:0] db_cnt;
  logic               btn_level_d;
  logic               rise_c;
  logic               match_c;
  logic [DIGIT_W-1:0] code_digit_c;

  // Two-flop synchronisers for the asynchronous button and switches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1     <= 1'b0;
      sync_btn   <= 1'b0;
      dig_s1     <= '0;
      sync_digit <= '0;
    end else begin
      btn_s1     <= btn_enter_raw;
      sync_btn   <= btn_s1;
      dig_s1     <= digit_sw;
      sync_digit <= dig_s1;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (sync_btn == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt    <= '0;
      btn_level <= ~btn_level;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_comb begin
    code_digit_c = '0;
    case (digit_index)
      2'd0:    code_digit_c = CODE0;
      2'd1:    code_digit_c = CODE1;
      2'd2:    code_digit_c = CODE2;
      default: code_digit_c = '0;
    endcase
    rise_c  = btn_level & ~btn_level_d;
    match_c = (digit_index != 2'd3) && (sync_digit == code_digit_c);
  end

  // Pulse and digit verdict are registered together, suppressed during lockout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_level_d   <= 1'b0;
      enter         <= 1'b0;
      correct_digit <= 1'b0;
    end else begin
      btn_level_d   <= btn_level;
      enter         <= rise_c & ~lockout;
      correct_digit <= rise_c & match_c & ~lockout;
    end
  end

  // Position tracker follows the lock FSM: advance on a correct digit, else restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_index <= 2'd0;
    end else if (enter) begin
      if (correct_digit && (digit_index != 2'd3)) digit_index <= digit_index + 2'd1;
      else                                        digit_index <= 2'd0;
    end
  end

`ifdef LOCKOUT_EN
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  logic [FAIL_W-1:0] fail_cnt;
  logic [LOCK_W-1:0] lock_cnt;

  // Consecutive wrong digits arm a fixed-length lockout window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_cnt <= '0;
      lock_cnt <= '0;
      lockout  <= 1'b0;
    end else if (lockout) begin
      if (lock_cnt == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
        lock_cnt <= '0;
        lockout  <= 1'b0;
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end else if (enter) begin
      if (correct_digit || (digit_index == 2'd3)) begin
        fail_cnt <= '0;
      end else if (fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
        fail_cnt <= '0;
        lockout  <= 1'b1;
      end else begin
        fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end
`else
  assign lockout = 1'b0;

  // Lockout parameters only matter when the feature is built in
  if ((MAX_FAILS == 0) || (LOCKOUT_CYCLES == 0)) begin : g_lockout_cfg_unused
  end
`endif

endmodule

// File: tb/tb_code_entry_frontend.sv
// Bench for code_entry_frontend: vector table, reset/lockout sequences and random presses
// checked against a press-level model. Define LOCKOUT_EN to cover the lockout build.
module tb_code_entry_frontend;

  localparam int unsigned DC   = 4;
  localparam int unsigned LOCK = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_enter_raw;
  logic [3:0] digit_sw;
  logic       enter;
  logic       correct_digit;
  logic [1:0] digit_index;
  logic       btn_level;
  logic       lockout;

  int n_checks = 0;
  int n_fail   = 0;
  int lo_run   = 0;
  int lo_last  = 0;

  typedef struct {
    logic [3:0] digit;
    bit         bounce;
    int         hold;
    logic       exp_corr;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t tbl [8];
  logic [3:0] code_m [3];

  code_entry_frontend #(
    .DIGIT_W(4), .DEBOUNCE_CYCLES(DC), .DB_CNT_W(16),
    .CODE0(4'd3), .CODE1(4'd7), .CODE2(4'd1),
    .MAX_FAILS(3), .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk(clk), .reset(reset), .btn_enter_raw(btn_enter_raw), .digit_sw(digit_sw),
    .enter(enter), .correct_digit(correct_digit), .digit_index(digit_index),
    .btn_level(btn_level), .lockout(lockout)
  );

  always #5 clk = ~clk;

  // Lockout run-length recorder
  always @(negedge clk) begin
    if (lockout === 1'b1) lo_run = lo_run + 1;
    else if (lo_run != 0) begin
      lo_last = lo_run;
      lo_run  = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_enter_raw = 1'b0;
    digit_sw = 4'd0;
    step(); step(); step();
    reset = 1'b0;
    step();
  endtask

  // One press: expect exp_pulses enter pulses, the pulse 7 cycles after the last raw rise
  task automatic press(input string tag, input logic [3:0] d, input bit bounce, input int hold,
                       input int exp_pulses, input logic exp_corr, input logic [1:0] exp_idx);
    int pulses = 0;
    int pulse_step = -1;
    logic corr_at = 1'b0;
    logic corr_after = 1'b0;
    logic lvl5 = 1'b0;
    logic lvl6 = 1'b0;
    logic [1:0] idx_before, idx_at, idx_after;
    idx_before = digit_index;
    idx_at = 2'd0;
    idx_after = 2'd0;
    digit_sw = d;
    if (bounce) begin
      btn_enter_raw = 1'b1; step();
      btn_enter_raw = 1'b0; step();
    end
    btn_enter_raw = 1'b1;
    for (int k = 1; k <= 8 + hold; k++) begin
      step();
      if (k == 5) lvl5 = btn_level;
      if (k == 6) lvl6 = btn_level;
      if (enter === 1'b1) begin
        pulses++;
        if (pulse_step < 0) begin
          pulse_step = k;
          corr_at = correct_digit;
          idx_at = digit_index;
        end
      end
      if (k == 8) begin
        idx_after = digit_index;
        corr_after = correct_digit;
      end
    end
    btn_enter_raw = 1'b0;
    for (int k = 0; k < int'(DC) + 4; k++) begin
      step();
      if (enter === 1'b1) pulses++;
    end
    check({tag, ".pulses"}, pulses, exp_pulses);
    check({tag, ".btn_level_rise"}, {lvl5, lvl6}, 2'b01);
    check({tag, ".idx_after"}, idx_after, exp_idx);
    if (exp_pulses == 1) begin
      check({tag, ".latency"}, pulse_step, 7);
      check({tag, ".correct"}, corr_at, exp_corr);
      check({tag, ".idx_at_pulse"}, idx_at, idx_before);
      check({tag, ".correct_low"}, corr_after, 1'b0);
    end
  endtask

  task automatic wait_lockout_end(input string tag);
    for (int i = 0; i < int'(LOCK) + 10 && lockout === 1'b1; i++) step();
    step();
    check({tag, ".lockout_fell"}, lockout, 1'b0);
    check({tag, ".lockout_len"}, lo_last, LOCK);
  endtask

  initial begin
    int   m_idx;
    int   m_fails;
    logic m_corr;
    logic m_lock;
    logic [3:0] d;
    int   pulses;
    int   pulse_step;

    code_m[0] = 4'd3; code_m[1] = 4'd7; code_m[2] = 4'd1;
    tbl[0] = '{digit: 4'd3, bounce: 1'b0, hold: 3,  exp_corr: 1'b1, exp_idx: 2'd1};
    tbl[1] = '{digit: 4'd7, bounce: 1'b1, hold: 10, exp_corr: 1'b1, exp_idx: 2'd2};
    tbl[2] = '{digit: 4'd1, bounce: 1'b0, hold: 2,  exp_corr: 1'b1, exp_idx: 2'd3};
    tbl[3] = '{digit: 4'd9, bounce: 1'b0, hold: 2,  exp_corr: 1'b0, exp_idx: 2'd0};
    tbl[4] = '{digit: 4'd3, bounce: 1'b1, hold: 2,  exp_corr: 1'b1, exp_idx: 2'd1};
    tbl[5] = '{digit: 4'd5, bounce: 1'b0, hold: 2,  exp_corr: 1'b0, exp_idx: 2'd0};
    tbl[6] = '{digit: 4'd3, bounce: 1'b0, hold: 2,  exp_corr: 1'b1, exp_idx: 2'd1};
    tbl[7] = '{digit: 4'd3, bounce: 1'b0, hold: 2,  exp_corr: 1'b0, exp_idx: 2'd0};

    reset = 1'b1;
    btn_enter_raw = 1'b0;
    digit_sw = 4'd0;
    #1;
    check("reset_outputs", {enter, correct_digit, digit_index, btn_level, lockout}, 6'd0);
    step(); step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++)
      press($sformatf("vec%0d", i), tbl[i].digit, tbl[i].bounce, tbl[i].hold,
            1, tbl[i].exp_corr, tbl[i].exp_idx);

    // Reset asserted mid-debounce while the button stays held
    do_reset();
    digit_sw = 4'd3;
    btn_enter_raw = 1'b1;
    step(); step(); step(); step();
    reset = 1'b1;
    #1;
    check("midreset_outputs", {enter, correct_digit, digit_index, btn_level, lockout}, 6'd0);
    step(); step();
    check("midreset_no_pulse", enter, 1'b0);
    reset = 1'b0;
    pulses = 0;
    pulse_step = -1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (enter === 1'b1) begin
        pulses++;
        if (pulse_step < 0) pulse_step = k;
      end
    end
    btn_enter_raw = 1'b0;
    for (int k = 0; k < int'(DC) + 4; k++) begin
      step();
      if (enter === 1'b1) pulses++;
    end
    check("held_reset.pulses", pulses, 1);
    check("held_reset.latency", pulse_step, 7);
    check("held_reset.idx", digit_index, 2'd1);

`ifdef LOCKOUT_EN
    // Three wrong digits lock entry; a press during lockout is swallowed
    do_reset();
    press("lk_w1", 4'd9, 1'b0, 2, 1, 1'b0, 2'd0);
    press("lk_w2", 4'd9, 1'b0, 2, 1, 1'b0, 2'd0);
    press("lk_w3", 4'd9, 1'b0, 2, 1, 1'b0, 2'd0);
    check("lk_active", lockout, 1'b1);
    press("lk_swallow", 4'd3, 1'b0, 0, 0, 1'b0, 2'd0);
    wait_lockout_end("lk");
    press("lk_c0", 4'd3, 1'b0, 2, 1, 1'b1, 2'd1);
    press("lk_c1", 4'd7, 1'b0, 2, 1, 1'b1, 2'd2);
    press("lk_c2", 4'd1, 1'b0, 2, 1, 1'b1, 2'd3);
`endif

    // Random presses against a press-level model of the code rules
    do_reset();
    m_idx = 0;
    m_fails = 0;
    for (int n = 0; n < 30; n++) begin
      if (($urandom_range(0, 1) == 1) && (m_idx < 3)) d = code_m[m_idx];
      else d = 4'($urandom_range(0, 15));
      m_corr = (m_idx < 3) && (d == code_m[m_idx]);
      m_lock = 1'b0;
`ifdef LOCKOUT_EN
      if (m_idx < 3 && !m_corr) begin
        m_fails++;
        if (m_fails == 3) begin
          m_fails = 0;
          m_lock = 1'b1;
        end
      end else begin
        m_fails = 0;
      end
`endif
      m_idx = m_corr ? m_idx + 1 : 0;
      press($sformatf("rnd%0d", n), d, 1'($urandom_range(0, 1)), $urandom_range(0, 5),
            1, m_corr, 2'(m_idx));
      check($sformatf("rnd%0d.lockout", n), lockout, m_lock);
      if (m_lock) wait_lockout_end($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
